// File: rtl/mem_access_stage.sv
// Memory-access stage after the ALU: byte/half/word loads and stores against a
// variable-latency data memory, with misalignment and timeout reporting.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       store_data,
  input  logic              mem_en,
  input  logic [2:0]        mem_op,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_reg_write,
  output logic              err
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  function automatic logic is_store(input logic [2:0] op);
    return op[2] && (op[1:0] != 2'b00);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] d);
    case (op)
      OP_SH:   return {2{d[15:0]}};
      OP_SB:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'b00:   byte_v = w[7:0];
      2'b01:   byte_v = w[15:8];
      2'b10:   byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    case (op)
      OP_LH:   return {{16{half[15]}}, half};
      OP_LHU:  return {16'h0000, half};
      OP_LB:   return {{24{byte_v[7]}}, byte_v};
      OP_LBU:  return {24'h000000, byte_v};
      default: return w;
    endcase
  endfunction

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic              rw_q;

  logic              ex_ready_q, dm_req_q, dm_we_q, wb_valid_q, wb_reg_write_q, err_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [3:0]        dm_be_q;
  logic [31:0]       dm_wdata_q, wb_data_q;
  logic [4:0]        wb_rd_q;

  logic accept_d, misalign_d;

  assign accept_d   = ex_valid && ex_ready_q && (state_q == IDLE);
  assign misalign_d = is_misaligned(mem_op, alu_result[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ex_ready_q     <= 1'b0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= '0;
      dm_be_q        <= 4'b0000;
      dm_wdata_q     <= 32'h0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'h0;
      wb_reg_write_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          ex_ready_q <= 1'b1;
          if (accept_d) begin
            if (!mem_en) begin
              wb_valid_q     <= 1'b1;
              wb_data_q      <= 32'(alu_result);
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= reg_write_in;
            end else if (misalign_d) begin
              wb_valid_q     <= 1'b1;
              err_q          <= 1'b1;
              wb_data_q      <= 32'h0;
              wb_rd_q        <= rd_in;
              wb_reg_write_q <= 1'b0;
            end else begin
              // Request fields are frozen here and held for the whole access.
              state_q    <= ACCESS;
              ex_ready_q <= 1'b0;
              cnt_q      <= '0;
              dm_req_q   <= 1'b1;
              dm_we_q    <= is_store(mem_op);
              dm_addr_q  <= {alu_result[ADDR_W-1:2], 2'b00};
              dm_be_q    <= is_store(mem_op) ? store_be(mem_op, alu_result[1:0]) : 4'b1111;
              dm_wdata_q <= is_store(mem_op) ? store_wdata(mem_op, store_data) : 32'h0;
              op_q       <= mem_op;
              off_q      <= alu_result[1:0];
              rd_q       <= rd_in;
              rw_q       <= reg_write_in;
            end
          end
        end
        ACCESS: begin
          // An ack in the final timeout cycle takes priority over the abort.
          if (dm_ack) begin
            state_q    <= IDLE;
            ex_ready_q <= 1'b1;
            dm_req_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            if (is_store(op_q)) begin
              wb_data_q      <= 32'h0;
              wb_reg_write_q <= 1'b0;
            end else begin
              wb_data_q      <= load_extract(op_q, off_q, dm_rdata);
              wb_reg_write_q <= rw_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q        <= IDLE;
            ex_ready_q     <= 1'b1;
            dm_req_q       <= 1'b0;
            wb_valid_q     <= 1'b1;
            err_q          <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_data_q      <= 32'h0;
            wb_reg_write_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready     = ex_ready_q;
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = dm_addr_q;
  assign dm_be        = dm_be_q;
  assign dm_wdata     = dm_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_result, store_data;
  logic        mem_en;
  logic [2:0]  mem_op;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write, err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_en(mem_en),
    .mem_op(mem_op), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size decides alignment, lanes and extension arithmetically.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rw_word, output logic mis, output logic we,
                       output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld);
    int unsigned sz, lane;
    logic [31:0] raw;
    sz   = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    lane = a % 4;
    mis  = (a % sz) != 0;
    we   = op >= 3'd5;
    if (we) begin
      be = 4'(((1 << sz) - 1) << lane);
      wd = (sz == 4) ? sd : (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001
                                      : (sd & 32'hFF) * 32'h0101_0101;
      ld = 32'h0;
    end else begin
      be  = 4'hF;
      wd  = 32'h0;
      raw = (sz == 4) ? rw_word : (rw_word >> (8 * lane)) & ((32'h1 << (8 * sz)) - 1);
      if ((op == 3'd1 || op == 3'd3) && raw >= (32'h1 << (8 * sz - 1)))
        raw = raw - (32'h1 << (8 * sz));
      ld = raw;
    end
  endtask

  task automatic run_mem(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int waitc, input logic [4:0] rd,
                         input logic rw, input logic mis, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] wbd);
    chk1("accept_ready", ex_ready, 1'b1);
    ex_valid = 1'b1; mem_en = 1'b1; mem_op = op; alu_result = addr;
    store_data = sdata; rd_in = rd; reg_write_in = rw;
    step();
    ex_valid = 1'b0;
    if (mis) begin
      chk1("mis_no_req", dm_req, 1'b0);
      chk1("mis_wb_valid", wb_valid, 1'b1);
      chk1("mis_err", err, 1'b1);
      chk1("mis_reg_write", wb_reg_write, 1'b0);
      step();
      chk1("mis_pulse_end", wb_valid, 1'b0);
      return;
    end
    for (int k = 0; k <= waitc; k++) begin
      chk1("acc_req", dm_req, 1'b1);
      chk1("acc_ready_low", ex_ready, 1'b0);
      chk1("acc_we", dm_we, we);
      chk("acc_addr", dm_addr, addr & 32'hFFFF_FFFC);
      chk("acc_be", 32'(dm_be), 32'(be));
      if (we) chk("acc_wdata", dm_wdata, wdata);
      chk1("acc_no_wb", wb_valid, 1'b0);
      if (k == waitc) begin
        dm_ack = 1'b1;
        dm_rdata = rdata;
      end
      step();
    end
    dm_ack = 1'b0;
    chk1("wb_valid", wb_valid, 1'b1);
    chk1("wb_err", err, 1'b0);
    chk("wb_data", wb_data, wbd);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk1("wb_reg_write", wb_reg_write, we ? 1'b0 : rw);
    chk1("req_dropped", dm_req, 1'b0);
    chk1("ready_back", ex_ready, 1'b1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, sdata, rdata;
    int          waitc;
    logic        mis, we;
    logic [3:0]  be;
    logic [31:0] wdata, wbd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic m_mis, m_we;
    logic [3:0] m_be;
    logic [31:0] m_wd, m_ld, a, sd, rdw;
    logic [2:0] op;

    tbl[0]  = '{3'd3, 32'h1002, 32'h0, 32'h1280_3456, 3, 1'b0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{3'd4, 32'h1002, 32'h0, 32'h1280_3456, 3, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0000_0080};
    tbl[2]  = '{3'd6, 32'h2006, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b1, 4'hC, 32'hBEEF_BEEF, 32'h0};
    tbl[3]  = '{3'd0, 32'h3001, 32'h0, 32'h0, 0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0};
    tbl[4]  = '{3'd1, 32'h1002, 32'h0, 32'h8000_3456, 0, 1'b0, 1'b0, 4'hF, 32'h0, 32'hFFFF_8000};
    tbl[5]  = '{3'd2, 32'h1000, 32'h0, 32'h1234_F00D, 2, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0000_F00D};
    tbl[6]  = '{3'd0, 32'h0040, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D};
    tbl[7]  = '{3'd7, 32'h5003, 32'h1234_56AB, 32'h0, 1, 1'b0, 1'b1, 4'h8, 32'hABAB_ABAB, 32'h0};
    tbl[8]  = '{3'd5, 32'h6000, 32'h0BAD_F00D, 32'h0, 15, 1'b0, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0};
    tbl[9]  = '{3'd1, 32'h1001, 32'h0, 32'h0, 0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0};
    tbl[10] = '{3'd6, 32'h2003, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0};

    reset = 1'b1; ex_valid = 1'b0; alu_result = '0; store_data = '0; mem_en = 1'b0;
    mem_op = '0; rd_in = '0; reg_write_in = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    step(); step();
    chk1("rst_ready", ex_ready, 1'b0);
    chk1("rst_req", dm_req, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk1("rst_err", err, 1'b0);
    reset = 1'b0;
    step();
    chk1("post_rst_ready", ex_ready, 1'b1);

    // Back-to-back non-memory records.
    ex_valid = 1'b1; mem_en = 1'b0; alu_result = 32'h5; rd_in = 5'd3; reg_write_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) ex_valid = 1'b0;
      chk1("nm_wb_valid", wb_valid, 1'b1);
      chk("nm_wb_data", wb_data, 32'h5);
      chk("nm_wb_rd", 32'(wb_rd), 32'd3);
      chk1("nm_reg_write", wb_reg_write, 1'b1);
      chk1("nm_err", err, 1'b0);
      chk1("nm_ready", ex_ready, 1'b1);
    end
    step();
    chk1("nm_idle", wb_valid, 1'b0);

    for (int i = 0; i < 11; i++)
      run_mem(tbl[i].op, tbl[i].addr, tbl[i].sdata, tbl[i].rdata, tbl[i].waitc, 5'(i + 1),
              1'b1, tbl[i].mis, tbl[i].we, tbl[i].be, tbl[i].wdata, tbl[i].wbd);

    // Timeout: ack never arrives.
    ex_valid = 1'b1; mem_en = 1'b1; mem_op = 3'd0; alu_result = 32'h7000; rd_in = 5'd9;
    reg_write_in = 1'b1;
    step();
    ex_valid = 1'b0;
    cnt = 0;
    while (dm_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", 32'(cnt), 32'd16);
    chk1("to_wb_valid", wb_valid, 1'b1);
    chk1("to_err", err, 1'b1);
    chk1("to_reg_write", wb_reg_write, 1'b0);
    chk1("to_ready", ex_ready, 1'b1);
    step();
    chk1("to_err_pulse", err, 1'b0);

    // Reset in the second access cycle, then a late ack.
    ex_valid = 1'b1; mem_en = 1'b1; mem_op = 3'd0; alu_result = 32'h8000;
    step();
    ex_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    chk1("mr_req", dm_req, 1'b0);
    chk1("mr_wb_valid", wb_valid, 1'b0);
    chk1("mr_we", dm_we, 1'b0);
    chk("mr_addr", dm_addr, 32'h0);
    chk("mr_wb_data", wb_data, 32'h0);
    step();
    dm_ack = 1'b0;
    chk1("mr_late_ack_wb", wb_valid, 1'b0);
    chk1("mr_ready", ex_ready, 1'b1);
    chk1("mr_req_idle", dm_req, 1'b0);

    // Randomized transactions against the model.
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sd  = $urandom;
      rdw = $urandom;
      model(op, a, sd, rdw, m_mis, m_we, m_be, m_wd, m_ld);
      run_mem(op, a, sd, rdw, int'($urandom_range(0, 5)), 5'($urandom), 1'($urandom),
              m_mis, m_we, m_be, m_wd, m_ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
